ugemm_tile_sched: RTL and testbench

- Tile-level sequencer for the weight-stationary, rate-coded uGEMM systolic array.
- For one weight tile it drives, into the top-left PE:
  - weight clear and load;
  - per-vector input and accumulator clear;
  - the unary bitstream compute window, with ifm valid/ready stall;
  - the mac_done pulse;
  - a drain period.
- Also generates the shared rate-coding random number (randW/randW_inv) broadcast along the array.
- PEs forward these strobes with one-cycle skew per hop.

---
 rtl/ugemm_tile_sched.sv | 178 +++++++++++++++++
 tb/tb_ugemm_tile_sched.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ugemm_tile_sched.sv
// Tile-level sequencer for the weight-stationary uGEMM systolic array: weight load,
// per-vector clear/compute/mac_done, wavefront drain, and the shared rate-coding number.
module ugemm_tile_sched #(
  parameter int unsigned IWIDTH = 8,
  parameter int unsigned ROWS   = 4,
  parameter int unsigned COLS   = 4,
  parameter int unsigned VWIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [VWIDTH-1:0]        num_vec,
  input  logic [IWIDTH-2:0]        len_m1,
  input  logic                     ifm_valid,
  output logic                     ifm_ready,
  output logic                     wght_rd,
  output logic [$clog2(ROWS)-1:0]  wrow_idx,
  output logic                     en_i,
  output logic                     clr_i,
  output logic                     en_w,
  output logic                     clr_w,
  output logic                     en_o,
  output logic                     clr_o,
  output logic                     mac_done,
  output logic [IWIDTH-1:0]        randW,
  output logic [IWIDTH-1:0]        randW_inv,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned CW         = IWIDTH - 1;
  localparam int unsigned RW         = $clog2(ROWS);
  localparam int unsigned FW         = $clog2(ROWS + COLS);
  localparam int unsigned FLUSH_LAST = ROWS + COLS - 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WCLR,
    S_WLOAD,
    S_OCLR,
    S_COMP,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [VWIDTH-1:0]   vrem_q, vrem_d;
  logic [CW-1:0]       len_q, len_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [RW-1:0]       row_q, row_d;
  logic [FW-1:0]       fl_q, fl_d;
  logic                mac_done_q, mac_done_d;
  logic                done_q, done_d;
  logic                ready_q, busy_q, clr_w_q, en_w_q, clr_io_q;
  logic [CW-1:0]       rev_d;
  logic [IWIDTH-1:0]   rand_q, rand_inv_q;

  function automatic logic [CW-1:0] bitrev(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    for (int i = 0; i < int'(CW); i++) begin
      r[i] = v[CW-1-i];
    end
    return r;
  endfunction

  // Next-state and next-output decode; counters idle at zero outside their state.
  always_comb begin
    state_d    = state_q;
    vrem_d     = vrem_q;
    len_d      = len_q;
    cnt_d      = '0;
    row_d      = '0;
    fl_d       = '0;
    mac_done_d = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_vec != '0) begin
            state_d = S_WCLR;
            vrem_d  = num_vec;
            len_d   = len_m1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_WCLR: state_d = S_WLOAD;
      S_WLOAD: begin
        if (row_q == RW'(ROWS - 1)) begin
          state_d = S_OCLR;
        end else begin
          row_d = row_q + RW'(1);
        end
      end
      S_OCLR: state_d = S_COMP;
      S_COMP: begin
        cnt_d = cnt_q;
        if (ifm_valid) begin
          if (cnt_q == len_q) begin
            mac_done_d = 1'b1;
            vrem_d     = vrem_q - VWIDTH'(1);
            cnt_d      = '0;
            state_d    = (vrem_q == VWIDTH'(1)) ? S_FLUSH : S_OCLR;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_FLUSH: begin
        if (fl_q == FW'(FLUSH_LAST)) begin
          state_d = S_DONE;
        end else begin
          fl_d = fl_q + FW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_DONE) begin
      done_d = 1'b1;
    end
    rev_d = bitrev(cnt_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      vrem_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      row_q      <= '0;
      fl_q       <= '0;
      mac_done_q <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      clr_w_q    <= 1'b0;
      en_w_q     <= 1'b0;
      clr_io_q   <= 1'b0;
      rand_q     <= '0;
      rand_inv_q <= '0;
    end else begin
      state_q    <= state_d;
      vrem_q     <= vrem_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      fl_q       <= fl_d;
      mac_done_q <= mac_done_d;
      done_q     <= done_d;
      ready_q    <= (state_d == S_COMP);
      busy_q     <= (state_d != S_IDLE);
      clr_w_q    <= (state_d == S_WCLR);
      en_w_q     <= (state_d == S_WLOAD);
      clr_io_q   <= (state_d == S_OCLR);
      rand_q     <= {1'b0, rev_d};
      rand_inv_q <= {1'b0, ~rev_d};
    end
  end

  // Enables qualify the registered compute window with the live valid so a stall gates them.
  assign en_i      = ready_q & ifm_valid;
  assign en_o      = ready_q & ifm_valid;
  assign ifm_ready = ready_q;
  assign wght_rd   = en_w_q;
  assign en_w      = en_w_q;
  assign clr_w     = clr_w_q;
  assign wrow_idx  = row_q;
  assign clr_i     = clr_io_q;
  assign clr_o     = clr_io_q;
  assign mac_done  = mac_done_q;
  assign randW     = rand_q;
  assign randW_inv = rand_inv_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ugemm_tile_sched.sv
// Bench for ugemm_tile_sched: per-cycle expected traces built from a schedule model.
module tb_ugemm_tile_sched;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int MAXA = 8192;

  logic        clk, rst, start, ifm_valid;
  logic [15:0] num_vec;
  logic [6:0]  len_m1;
  logic        ifm_ready, wght_rd, en_i, clr_i, en_w, clr_w, en_o, clr_o, mac_done, busy, done;
  logic [1:0]  wrow_idx;
  logic [7:0]  randW, randW_inv;

  ugemm_tile_sched #(.IWIDTH(8), .ROWS(ROWS), .COLS(COLS), .VWIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .len_m1(len_m1),
    .ifm_valid(ifm_valid), .ifm_ready(ifm_ready), .wght_rd(wght_rd), .wrow_idx(wrow_idx),
    .en_i(en_i), .clr_i(clr_i), .en_w(en_w), .clr_w(clr_w), .en_o(en_o), .clr_o(clr_o),
    .mac_done(mac_done), .randW(randW), .randW_inv(randW_inv), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = -1;
  bit chk_en = 1'b0;

  int st[MAXA], nv[MAXA], len[MAXA], vld[MAXA];
  int e_busy[MAXA], e_clrw[MAXA], e_enw[MAXA], e_row[MAXA], e_clr[MAXA];
  int e_ready[MAXA], e_en[MAXA], e_macd[MAXA], e_done[MAXA], e_rand[MAXA], e_rinv[MAXA];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int rev7(input int x);
    int r = 0;
    for (int i = 0; i < 7; i++) r = (r << 1) | ((x >> i) & 1);
    return r;
  endfunction

  task automatic clear_stim();
    for (int i = 0; i < MAXA; i++) begin
      st[i] = 0; nv[i] = 0; len[i] = 0; vld[i] = 1;
    end
  endtask

  // Lays out each accepted tile as a timeline: clear, load rows, per-vector clear+beats, drain, done.
  task automatic build_model(input int n);
    int idle_from, t, cnt, beats;
    for (int i = 0; i < MAXA; i++) begin
      e_busy[i] = 0; e_clrw[i] = 0; e_enw[i] = 0; e_row[i] = 0; e_clr[i] = 0;
      e_ready[i] = 0; e_en[i] = 0; e_macd[i] = 0; e_done[i] = 0;
      e_rand[i] = 0; e_rinv[i] = 127;
    end
    idle_from = 0;
    for (int c = 0; c < n; c++) begin
      if (st[c] != 0 && c >= idle_from) begin
        if (nv[c] == 0) begin
          e_done[c+1] = 1;
          idle_from = c + 1;
        end else begin
          t = c + 1;
          e_clrw[t] = 1; e_busy[t] = 1; t++;
          for (int r = 0; r < ROWS; r++) begin
            e_enw[t] = 1; e_row[t] = r; e_busy[t] = 1; t++;
          end
          for (int v = 0; v < nv[c]; v++) begin
            e_clr[t] = 1; e_busy[t] = 1; t++;
            cnt = 0; beats = 0;
            while (beats <= len[c] && t < MAXA - 32) begin
              e_ready[t] = 1; e_busy[t] = 1;
              e_rand[t] = rev7(cnt); e_rinv[t] = 127 - rev7(cnt);
              if (vld[t] != 0) begin
                e_en[t] = 1; beats++; cnt = (cnt + 1) % 128;
              end
              t++;
            end
            e_macd[t] = 1;
          end
          for (int f = 0; f < ROWS + COLS - 1; f++) begin
            e_busy[t] = 1; t++;
          end
          e_busy[t] = 1; e_done[t] = 1;
          idle_from = t + 1;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", int'(busy), e_busy[cyc]);
      chk("clr_w", int'(clr_w), e_clrw[cyc]);
      chk("en_w", int'(en_w), e_enw[cyc]);
      chk("wght_rd", int'(wght_rd), e_enw[cyc]);
      chk("wrow_idx", int'(wrow_idx), e_row[cyc]);
      chk("clr_i", int'(clr_i), e_clr[cyc]);
      chk("clr_o", int'(clr_o), e_clr[cyc]);
      chk("ifm_ready", int'(ifm_ready), e_ready[cyc]);
      chk("en_i", int'(en_i), e_en[cyc]);
      chk("en_o", int'(en_o), e_en[cyc]);
      chk("mac_done", int'(mac_done), e_macd[cyc]);
      chk("done", int'(done), e_done[cyc]);
      chk("randW", int'(randW), e_rand[cyc]);
      chk("randW_inv", int'(randW_inv), e_rinv[cyc]);
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_strobes"}, int'({clr_w, en_w, wght_rd, clr_i, clr_o, ifm_ready, en_i, en_o, mac_done}), 0);
    chk({tag, "_wrow"}, int'(wrow_idx), 0);
    chk({tag, "_randW"}, int'(randW), 0);
    chk({tag, "_randW_inv"}, int'(randW_inv), 0);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst = 1'b1; start = 1'b0; ifm_valid = 1'b0; num_vec = '0; len_m1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_seg(input int n);
    for (int c = 0; c < n; c++) begin
      cyc = c;
      start = (st[c] != 0);
      num_vec = 16'(nv[c]);
      len_m1 = 7'(len[c]);
      ifm_valid = (vld[c] != 0);
      chk_en = 1'b1;
      @(posedge clk);
      #1;
    end
    chk_en = 1'b0;
    start = 1'b0;
  endtask

  task automatic scen1();
    clear_stim();
    st[0] = 1; nv[0] = 2; len[0] = 3;
  endtask

  initial begin
    int sum;
    rst = 1'b1; start = 1'b0; ifm_valid = 1'b0; num_vec = '0; len_m1 = '0;

    // Two vectors, four beats each, no stalls.
    do_reset();
    scen1();
    build_model(30);
    cyc = -1;
    chk("pin_clrw1", e_clrw[1], 1);
    chk("pin_row5", e_row[5], 3);
    chk("pin_clr6", e_clr[6], 1);
    chk("pin_macd11", e_macd[11] + e_clr[11], 2);
    chk("pin_macd16", e_macd[16], 1);
    chk("pin_done23", e_done[23], 1);
    chk("pin_busy23_24", e_busy[23] * 2 + e_busy[24], 2);
    run_seg(30);

    // Same tile with a two-cycle stall.
    do_reset();
    scen1();
    vld[8] = 0; vld[9] = 0;
    build_model(32);
    cyc = -1;
    chk("pin_en8", e_en[8], 0);
    chk("pin_macd13", e_macd[13], 1);
    chk("pin_done25", e_done[25], 1);
    run_seg(32);

    // Full 128-beat stream exercises the bit-reversed counter and its wrap.
    do_reset();
    clear_stim();
    st[0] = 1; nv[0] = 1; len[0] = 127;
    build_model(160);
    cyc = -1;
    chk("pin_rand8", e_rand[8], 8'h40);
    chk("pin_rand9", e_rand[9], 8'h20);
    chk("pin_rinv8", e_rinv[8], 8'h3F);
    sum = 0;
    for (int i = 0; i < 160; i++) sum += e_en[i];
    chk("pin_en_count", sum, 128);
    chk("pin_done142", e_done[142], 1);
    run_seg(160);

    // Zero-vector start, then a tile with a start arriving mid-compute.
    do_reset();
    clear_stim();
    st[0] = 1; nv[0] = 0;
    st[2] = 1; nv[2] = 1; len[2] = 3;
    st[10] = 1; nv[10] = 1; len[10] = 3;
    build_model(30);
    cyc = -1;
    chk("pin_zero_done1", e_done[1], 1);
    chk("pin_zero_busy1", e_busy[1], 0);
    sum = 0;
    for (int i = 0; i < 30; i++) sum += e_done[i];
    chk("pin_done_count", sum, 2);
    chk("pin_done20", e_done[20], 1);
    run_seg(30);

    // Reset mid-tile aborts at once; a fresh start repeats the whole tile.
    do_reset();
    scen1();
    build_model(30);
    run_seg(9);
    cyc = 9;
    ifm_valid = 1'b1;
    #1 rst = 1'b1;
    #1 check_zero("midrst");
    repeat (3) begin
      @(posedge clk);
      #1 check_zero("midrst_hold");
    end
    do_reset();
    run_seg(30);

    // Randomised tiles, stalls and stray starts.
    for (int s = 0; s < 3; s++) begin
      do_reset();
      clear_stim();
      for (int i = 0; i < MAXA; i++) begin
        vld[i] = ($urandom_range(0, 3) != 0) ? 1 : 0;
        if (i < 500 && $urandom_range(0, 15) == 0) begin
          st[i] = 1;
          nv[i] = int'($urandom_range(0, 3));
          len[i] = ($urandom_range(0, 7) == 0) ? 127 : int'($urandom_range(0, 7));
        end
      end
      build_model(600);
      run_seg(600);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
